// File: rtl/delay_timer_pkg.sv
// Shared types for the delay_timer scheduler: FSM states, timer mode encodings
// and the completion-edge helper.
package delay_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } dts_state_e;

    // Timer mode as {mode_a, mode_b}
    typedef logic [1:0] dt_mode_t;

    localparam dt_mode_t DT_MODE_RISE_A = 2'b00;
    localparam dt_mode_t DT_MODE_FALL_A = 2'b01;
    localparam dt_mode_t DT_MODE_RISE_B = 2'b10;
    localparam dt_mode_t DT_MODE_FALL_B = 2'b11;

    // True when the timer output signals completion with a rising edge
    function automatic logic dt_done_on_rise(input dt_mode_t mode);
        logic rise;
        rise = 1'b0;
        case (mode)
            DT_MODE_RISE_A, DT_MODE_RISE_B: rise = 1'b1;
            DT_MODE_FALL_A, DT_MODE_FALL_B: rise = 1'b0;
            default:                        rise = 1'b0;
        endcase
        return rise;
    endfunction

endpackage

// File: rtl/delay_timer_sched_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping past N-1 back to 0.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int unsigned IW = $clog2(N);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IW'(sum);
    endfunction

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = wrap_add(ptr, i);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_idx    = idx;
                gnt[idx]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_timer_sched.sv
// Round-robin scheduler sharing one delay_timer among N_REQ requesters.
// Optional WAIT watchdog is compiled in with `define DTS_TIMEOUT_EN.
module delay_timer_sched
    import delay_timer_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned TRIG_W      = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      req_delay,
    input  logic [N_REQ*2-1:0]       req_mode,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [DW-1:0]            tmr_wb,
    output logic                     tmr_mode_a,
    output logic                     tmr_mode_b,
    output logic                     tmr_trigger,
    input  logic                     tmr_delay_out,
    output logic                     timeout
);

    localparam int unsigned IW  = $clog2(N_REQ);
    localparam int unsigned TCW = $clog2(TRIG_W + 1);

    if (N_REQ < 2 || N_REQ > 8 || DW < 1 || TRIG_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("delay_timer_sched: unsupported parameter value");
    end

    dts_state_e     state_q;
    dts_state_e     state_d;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  rr_ptr_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             req_any;
    logic [DW-1:0]    sel_delay;
    dt_mode_t         sel_mode;

    logic [TCW-1:0]   trig_cnt;
    logic [TCW-1:0]   trig_cnt_d;

    logic             sync1;
    logic             sync2;
    logic             pre_lvl;
    logic             rise_q;
    logic             fall_q;
    logic             edge_hit;
    logic             wd_expire;

    dt_mode_t         tmr_mode;
    logic [N_REQ-1:0] ack_d;
    logic             busy_d;
    logic             trig_d;
    logic [IW-1:0]    grant_d;
    logic [DW-1:0]    wb_d;
    dt_mode_t         mode_d;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign req_any  = |arb_gnt;
    assign tmr_mode = {tmr_mode_a, tmr_mode_b};
    assign edge_hit = dt_done_on_rise(tmr_mode) ? rise_q : fall_q;

    // One-hot mux of the winning requester's delay and mode slices
    always_comb begin
        sel_delay = '0;
        sel_mode  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_delay = req_delay[i*DW +: DW];
                sel_mode  = req_mode[i*2 +: 2];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr;
        trig_cnt_d = '0;
        grant_d    = grant_id;
        wb_d       = tmr_wb;
        mode_d     = tmr_mode;
        ack_d      = '0;
        busy_d     = 1'b0;
        trig_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_LOAD;
                    grant_d = arb_idx;
                    wb_d    = sel_delay;
                    mode_d  = sel_mode;
                end
            end
            ST_LOAD: begin
                state_d = (tmr_wb == '0) ? ST_DONE : ST_ARM;
            end
            ST_ARM: begin
                trig_cnt_d = trig_cnt + TCW'(1);
                if (trig_cnt == TCW'(TRIG_W - 1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (edge_hit || wd_expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DONE) begin
            ack_d = N_REQ'(1) << grant_id;
        end
        busy_d = (state_d != ST_IDLE);
        trig_d = (state_d == ST_ARM);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, capture registers and trigger counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            trig_cnt    <= '0;
            grant_id    <= '0;
            tmr_wb      <= '0;
            tmr_mode_a  <= 1'b0;
            tmr_mode_b  <= 1'b0;
            tmr_trigger <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
        end else begin
            rr_ptr      <= rr_ptr_d;
            trig_cnt    <= trig_cnt_d;
            grant_id    <= grant_d;
            tmr_wb      <= wb_d;
            tmr_mode_a  <= mode_d[1];
            tmr_mode_b  <= mode_d[0];
            tmr_trigger <= trig_d;
            ack         <= ack_d;
            busy        <= busy_d;
        end
    end

    // delay_out synchronizer; edges are only recorded while waiting so
    // anything that happened during ARM cannot complete the transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            pre_lvl <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1   <= tmr_delay_out;
            sync2   <= sync1;
            pre_lvl <= sync2;
            rise_q  <= (state_q == ST_WAIT) && sync2 && !pre_lvl;
            fall_q  <= (state_q == ST_WAIT) && !sync2 && pre_lvl;
        end
    end

`ifdef DTS_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

    logic [WDW-1:0] wd_cnt;

    assign wd_expire = (state_q == ST_WAIT) && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

    // Watchdog counts WAIT cycles and is held at zero elsewhere
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= (state_q == ST_WAIT) ? wd_cnt + WDW'(1) : '0;
            timeout <= wd_expire;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_delay_timer_sched.sv
// Directed bench for delay_timer_sched: vector table of single transactions
// plus hand-written contention, ARM-edge, reset and watchdog sequences.
module tb_delay_timer_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_delay;
    logic [7:0]  req_mode;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic [7:0]  tmr_wb;
    logic        tmr_mode_a;
    logic        tmr_mode_b;
    logic        tmr_trigger;
    logic        tmr_delay_out;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    delay_timer_sched #(
        .N_REQ       (4),
        .DW          (8),
        .TRIG_W      (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_delay     (req_delay),
        .req_mode      (req_mode),
        .ack           (ack),
        .busy          (busy),
        .grant_id      (grant_id),
        .tmr_wb        (tmr_wb),
        .tmr_mode_a    (tmr_mode_a),
        .tmr_mode_b    (tmr_mode_b),
        .tmr_trigger   (tmr_trigger),
        .tmr_delay_out (tmr_delay_out),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] delay;
        logic [7:0]  mode;
        logic [1:0]  exp_idx;
        logic [7:0]  exp_wb;
        logic        exp_a;
        logic        exp_b;
    } vec_t;

    vec_t vecs [7];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ack"},   32'(ack), 32'd0);
        chk({name, "_busy"},  32'(busy), 32'd0);
        chk({name, "_grant"}, 32'(grant_id), 32'd0);
        chk({name, "_wb"},    32'(tmr_wb), 32'd0);
        chk({name, "_modes"}, 32'({tmr_mode_a, tmr_mode_b}), 32'd0);
        chk({name, "_trig"},  32'(tmr_trigger), 32'd0);
        chk({name, "_tmo"},   32'(timeout), 32'd0);
    endtask

    // One complete transaction driven from IDLE; cycle P1 is the capture edge
    task automatic run_vec(input vec_t v, input int n);
        logic  rise;
        string tag;
        tag  = $sformatf("vec%0d", n);
        rise = ~v.exp_b;
        tmr_delay_out = ~rise;
        tick(4);
        req       = v.req;
        req_delay = v.delay;
        req_mode  = v.mode;
        tick(1);
        chk({tag, "_grant"}, 32'(grant_id), 32'(v.exp_idx));
        chk({tag, "_wb"},    32'(tmr_wb), 32'(v.exp_wb));
        chk({tag, "_modes"}, 32'({tmr_mode_a, tmr_mode_b}), 32'({v.exp_a, v.exp_b}));
        chk({tag, "_busy"},  32'(busy), 32'd1);
        chk({tag, "_trig0"}, 32'(tmr_trigger), 32'd0);
        req_delay = ~v.delay;
        req_mode  = ~v.mode;
        if (v.exp_wb == 8'd0) begin
            tick(1);
            chk({tag, "_zack"},  32'(ack), 32'(4'd1 << v.exp_idx));
            chk({tag, "_ztrig"}, 32'(tmr_trigger), 32'd0);
        end else begin
            tick(1);
            chk({tag, "_trig1"}, 32'(tmr_trigger), 32'd1);
            tick(1);
            chk({tag, "_trig2"}, 32'(tmr_trigger), 32'd1);
            tick(1);
            chk({tag, "_trig3"}, 32'(tmr_trigger), 32'd0);
            tmr_delay_out = rise;
            tick(3);
            chk({tag, "_early"}, 32'(ack), 32'd0);
            tick(1);
            chk({tag, "_ack"},   32'(ack), 32'(4'd1 << v.exp_idx));
            chk({tag, "_tmo"},   32'(timeout), 32'd0);
        end
        chk({tag, "_hold"}, 32'({tmr_wb, tmr_mode_a, tmr_mode_b}), 32'({v.exp_wb, v.exp_a, v.exp_b}));
        req = 4'b0000;
        tick(1);
        chk({tag, "_idle"},   32'(busy), 32'd0);
        chk({tag, "_ackend"}, 32'(ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic got;

        vecs[0] = '{4'b0010, {8'd4,  8'd3,   8'd20, 8'd1}, 8'b00_00_00_00, 2'd1, 8'd20,  1'b0, 1'b0};
        vecs[1] = '{4'b1111, {8'd40, 8'd30,  8'd25, 8'd10}, 8'b00_01_00_00, 2'd2, 8'd30,  1'b0, 1'b1};
        vecs[2] = '{4'b0011, {8'd9,  8'd8,   8'd7,  8'd6}, 8'b11_11_11_10, 2'd0, 8'd6,   1'b1, 1'b0};
        vecs[3] = '{4'b1001, {8'd0,  8'd5,   8'd5,  8'd5}, 8'b01_00_00_00, 2'd3, 8'd0,   1'b0, 1'b1};
        vecs[4] = '{4'b0100, {8'd1,  8'd255, 8'd1,  8'd1}, 8'b00_11_00_00, 2'd2, 8'd255, 1'b1, 1'b1};
        vecs[5] = '{4'b1110, {8'd77, 8'd2,   8'd3,  8'd4}, 8'b10_00_00_00, 2'd3, 8'd77,  1'b1, 1'b0};
        vecs[6] = '{4'b0001, {8'd0,  8'd0,   8'd0,  8'd1}, 8'b00_00_00_00, 2'd0, 8'd1,   1'b0, 1'b0};

        reset         = 1'b0;
        req           = '0;
        req_delay     = '0;
        req_mode      = '0;
        tmr_delay_out = 1'b0;
        tick(2);
        chk_all_zero("reset");
        reset = 1'b1;
        tick(2);

        // Contention: all four request with zero delay, grants rotate 0..3
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                tick(1);
                if (ack != 4'b0000) got = 1'b1;
            end
            chk("cont_ack_seen", 32'(got), 32'd1);
            chk("cont_grant", 32'(grant_id), 32'(k));
            chk("cont_ack", 32'(ack), 32'(1 << k));
            req[k] = 1'b0;
        end
        tick(2);
        req = 4'b1111;
        tick(1);
        chk("cont_wrap_grant", 32'(grant_id), 32'd0);
        tick(1);
        chk("cont_wrap_ack", 32'(ack), 32'd1);
        req = 4'b0000;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Falling-edge mode: synchronized fall lands inside ARM and is ignored
        tmr_delay_out = 1'b1;
        tick(4);
        req       = 4'b0001;
        req_delay = 32'd50;
        req_mode  = 8'b00_00_00_01;
        tick(1);
        chk("fall_grant", 32'(grant_id), 32'd0);
        chk("fall_modes", 32'({tmr_mode_a, tmr_mode_b}), 32'b01);
        tmr_delay_out = 1'b0;
        tick(1);
        chk("fall_trig1", 32'(tmr_trigger), 32'd1);
        tick(1);
        chk("fall_trig2", 32'(tmr_trigger), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk("fall_arm_edge", 32'(ack), 32'd0);
        end
        tmr_delay_out = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("fall_rise_ignored", 32'(ack), 32'd0);
        end
        tmr_delay_out = 1'b0;
        tick(3);
        chk("fall_early", 32'(ack), 32'd0);
        tick(1);
        chk("fall_ack", 32'(ack), 32'b0001);
        req = 4'b0000;
        tick(1);
        chk("fall_idle", 32'(busy), 32'd0);

        // Reset while waiting, then a pending req[2] is served from pointer 0
        tmr_delay_out = 1'b0;
        tick(4);
        req       = 4'b0001;
        req_delay = 32'd9;
        req_mode  = '0;
        tick(4);
        chk("rst_wait_busy", 32'(busy), 32'd1);
        tick(2);
        #2;
        reset     = 1'b0;
        req       = 4'b0100;
        req_delay = '0;
        #1;
        chk_all_zero("rst_async");
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("rst_grant", 32'(grant_id), 32'd2);
        chk("rst_busy", 32'(busy), 32'd1);
        tick(1);
        chk("rst_ack", 32'(ack), 32'b0100);
        chk("rst_trig", 32'(tmr_trigger), 32'd0);
        req = 4'b0000;
        tick(1);
        chk("rst_idle", 32'(busy), 32'd0);

`ifdef DTS_TIMEOUT_EN
        // Watchdog: delay_out stuck low, ack and timeout 16 cycles after WAIT entry
        tmr_delay_out = 1'b0;
        tick(4);
        req       = 4'b0010;
        req_delay = {8'd0, 8'd0, 8'd5, 8'd0};
        req_mode  = '0;
        tick(4);
        chk("tmo_wait_entry", 32'(tmr_trigger), 32'd0);
        tick(15);
        chk("tmo_early", 32'({ack, timeout}), 32'd0);
        tick(1);
        chk("tmo_ack", 32'(ack), 32'b0010);
        chk("tmo_flag", 32'(timeout), 32'd1);
        req = 4'b0000;
        tick(1);
        chk("tmo_end", 32'({ack, timeout}), 32'd0);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
